dsp_uart_tx: RTL



---
 rtl/dsp_uart_tx_pkg.sv | 25 ++
 rtl/dsp_uart_tx_fifo.sv | 75 +++++++
 rtl/dsp_uart_tx.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/dsp_uart_tx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dsp_uart_tx_pkg
//  Description : Shared types and frame constants for the OUT-path UART
//                transmitter (FSM state encoding, frame geometry).
//  Revision    : 1.0 - initial release
// ============================================================================
package dsp_uart_tx_pkg;

    // Transmit FSM states; encodings are fixed so they stay stable in dumps.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_t;

    // 8N1 frame geometry and bus word size.
    localparam int c_DATA_BITS      = 8;
    localparam int c_BYTES_PER_WORD = 2;
    localparam int c_WORD_W         = c_DATA_BITS * c_BYTES_PER_WORD;
    localparam int c_IDX_W          = $clog2(c_DATA_BITS);

endpackage : dsp_uart_tx_pkg
`default_nettype wire

// File: rtl/dsp_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo
//  Description : Single-clock first-word-fall-through FIFO. Pointers carry an
//                extra wrap bit so full and empty are unambiguous. When full,
//                a push in the same cycle as a pop is accepted (pop-then-push).
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int             c_AW      = $clog2(DEPTH);
    localparam logic [c_AW:0]  c_PTR_ONE = (c_AW + 1)'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW:0]    r_wr_ptr;
    logic [c_AW:0]    r_rd_ptr;
    logic             r_full;
    logic             r_empty;

    logic             w_do_pop;
    logic             w_do_push;
    logic [c_AW:0]    w_wr_nxt;
    logic [c_AW:0]    w_rd_nxt;

    // Qualify requests and compute next pointers; a pop frees the slot the
    // simultaneous push is allowed to reuse.
    always_comb begin
        w_do_pop  = pop & ~r_empty;
        w_do_push = push & (~r_full | w_do_pop);
        w_wr_nxt  = w_do_push ? (r_wr_ptr + c_PTR_ONE) : r_wr_ptr;
        w_rd_nxt  = w_do_pop  ? (r_rd_ptr + c_PTR_ONE) : r_rd_ptr;
    end

    // Pointer and flag registers; flags derive from next pointers so they are
    // consistent with occupancy right after each edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            r_wr_ptr <= w_wr_nxt;
            r_rd_ptr <= w_rd_nxt;
            r_full   <= (w_wr_nxt[c_AW] != w_rd_nxt[c_AW]) &&
                        (w_wr_nxt[c_AW-1:0] == w_rd_nxt[c_AW-1:0]);
            r_empty  <= (w_wr_nxt == w_rd_nxt);
        end
    end

    // Storage array; contents need no reset because the flags gate reads.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[c_AW-1:0]] <= din;
        end
    end

    assign dout  = r_mem[r_rd_ptr[c_AW-1:0]];
    assign full  = r_full;
    assign empty = r_empty;

endmodule : sync_fifo
`default_nettype wire

// File: rtl/dsp_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : dsp_uart_tx
//  Description : OUT-path sink. Captures 16-bit bus words on dsp_in_en into a
//                FIFO and serializes each as two 8N1 frames, low byte first.
//                Never back-pressures the CPU: writes to a full FIFO are
//                dropped and recorded in a sticky overflow flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module dsp_uart_tx
    import dsp_uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [c_WORD_W-1:0] in,
    input  logic                dsp_in_en,
    output logic                tx,
    output logic                busy,
    output logic                full,
    output logic                overflow
);

    localparam int                   c_BAUD_W    = $clog2(CLKS_PER_BIT);
    localparam logic [c_BAUD_W-1:0]  c_BAUD_LAST = c_BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [c_BAUD_W-1:0]  c_BAUD_ONE  = c_BAUD_W'(1);
    localparam logic [c_IDX_W-1:0]   c_IDX_LAST  = c_IDX_W'(c_DATA_BITS - 1);
    localparam logic [c_IDX_W-1:0]   c_IDX_ONE   = c_IDX_W'(1);

    uart_state_t          r_state;
    uart_state_t          w_state_nxt;
    logic [c_BAUD_W-1:0]  r_baud;
    logic [c_IDX_W-1:0]   r_bit_idx;
    logic [c_WORD_W-1:0]  r_shift;
    logic                 r_byte_sel;
    logic                 r_tx;
    logic                 r_busy;
    logic                 r_overflow;

    logic                 w_pop;
    logic                 w_push_acc;
    logic                 w_baud_last;
    logic                 w_idx_last;
    logic [c_WORD_W-1:0]  w_fifo_dout;
    logic                 w_fifo_full;
    logic                 w_fifo_empty;

    sync_fifo #(
        .WIDTH (c_WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (dsp_in_en),
        .pop   (w_pop),
        .din   (in),
        .dout  (w_fifo_dout),
        .full  (w_fifo_full),
        .empty (w_fifo_empty)
    );

    assign w_baud_last = (r_baud == c_BAUD_LAST);
    assign w_idx_last  = (r_bit_idx == c_IDX_LAST);
    assign w_push_acc  = dsp_in_en & (~w_fifo_full | w_pop);

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and FIFO pop decision. A pop only happens when a fresh word
    // is needed: from IDLE, or at the end of a high-byte stop bit.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_fifo_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = ST_START;
                end
            end
            ST_START: begin
                if (w_baud_last) begin
                    w_state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_baud_last && w_idx_last) begin
                    w_state_nxt = ST_STOP;
                end
            end
            ST_STOP: begin
                if (w_baud_last) begin
                    if (!r_byte_sel) begin
                        w_state_nxt = ST_START;
                    end else if (!w_fifo_empty) begin
                        w_pop       = 1'b1;
                        w_state_nxt = ST_START;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Baud counter, bit index and shift register. The word shifts right once
    // per data bit, so after eight bits the high byte sits in the low lane.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_baud     <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_byte_sel <= 1'b0;
        end else if (w_pop) begin
            r_shift    <= w_fifo_dout;
            r_byte_sel <= 1'b0;
            r_baud     <= '0;
        end else if (r_state != ST_IDLE) begin
            if (w_baud_last) begin
                r_baud <= '0;
                case (r_state)
                    ST_START: r_bit_idx <= '0;
                    ST_DATA: begin
                        r_shift   <= r_shift >> 1;
                        r_bit_idx <= r_bit_idx + c_IDX_ONE;
                    end
                    ST_STOP:  r_byte_sel <= ~r_byte_sel;
                    default:  r_bit_idx <= r_bit_idx;
                endcase
            end else begin
                r_baud <= r_baud + c_BAUD_ONE;
            end
        end
    end

    // Registered serial line: follows the current state one cycle later,
    // which gives the two-edge write-to-start latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx <= 1'b1;
        end else begin
            case (r_state)
                ST_START: r_tx <= 1'b0;
                ST_DATA:  r_tx <= r_shift[0];
                default:  r_tx <= 1'b1;
            endcase
        end
    end

    // Busy and sticky overflow. When the FSM is heading to IDLE no pop occurs,
    // so the FIFO is non-empty afterwards only if this edge accepts a write.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_busy     <= (w_state_nxt != ST_IDLE) | w_push_acc;
            r_overflow <= r_overflow | (dsp_in_en & w_fifo_full & ~w_pop);
        end
    end

    assign tx       = r_tx;
    assign busy     = r_busy;
    assign full     = w_fifo_full;
    assign overflow = r_overflow;

endmodule : dsp_uart_tx
`default_nettype wire
